// File: rtl/hazard_ctrl_pkg.sv
// Shared Tuse/Tnew and forward-select encodings for the hazard controller.
// Constants only; no logic, no latency, no flow control.
package hazard_ctrl_pkg;

  localparam int T_W = 3;

  localparam logic [T_W-1:0] TUSE_D = 3'd0;
  localparam logic [T_W-1:0] TUSE_E = 3'd1;
  localparam logic [T_W-1:0] TUSE_M = 3'd2;

  localparam logic [T_W-1:0] TNEW_D = 3'd0;
  localparam logic [T_W-1:0] TNEW_E = 3'd1;
  localparam logic [T_W-1:0] TNEW_M = 3'd2;

  localparam int FWD_RF = 0;
  localparam int FWD_E  = 1;
  localparam int FWD_M  = 2;
  localparam int FWD_W  = 3;

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracked stage: dst/wen/Tnew/operand addresses, bubble insert, saturating Tnew decrement.
// One edge of latency; never stalls itself, the bubble input overrides the loaded content.
module hazard_stage_reg #(
  parameter int REG_AW = 5,
  parameter int T_W    = 3,
  parameter bit DEC    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              in_wen,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [T_W-1:0]    in_tnew,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  output logic              wen,
  output logic [REG_AW-1:0] dst,
  output logic [T_W-1:0]    tnew,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt
);

  logic              wen_d,  wen_q;
  logic [REG_AW-1:0] dst_d,  dst_q;
  logic [T_W-1:0]    tnew_d, tnew_q;
  logic [REG_AW-1:0] rs_d,   rs_q;
  logic [REG_AW-1:0] rt_d,   rt_q;

  always_comb begin
    wen_d  = in_wen;
    dst_d  = in_dst;
    rs_d   = in_rs;
    rt_d   = in_rt;
    tnew_d = in_tnew;
    // The first stage takes the decoder's Tnew as-is; later stages count down to zero.
    if (DEC && (in_tnew != '0)) begin
      tnew_d = in_tnew - T_W'(1);
    end
    if (bubble) begin
      wen_d  = 1'b0;
      dst_d  = '0;
      tnew_d = '0;
      rs_d   = '0;
      rt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q  <= 1'b0;
      dst_q  <= '0;
      tnew_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      wen_q  <= wen_d;
      dst_q  <= dst_d;
      tnew_q <= tnew_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end

  assign wen  = wen_q;
  assign dst  = dst_q;
  assign tnew = tnew_q;
  assign rs   = rs_q;
  assign rt   = rt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard and forwarding controller for the stages after D.
// Stall/forward outputs are combinational (0 cycles); stall freezes D and bubbles E.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int REG_AW = 5,
  parameter int T_W    = hazard_ctrl_pkg::T_W,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [REG_AW-1:0]       d_rs,
  input  logic [REG_AW-1:0]       d_rt,
  input  logic                    d_use_rs,
  input  logic                    d_use_rt,
  input  logic [T_W-1:0]          d_tuse_rs,
  input  logic [T_W-1:0]          d_tuse_rt,
  input  logic                    d_wen,
  input  logic [REG_AW-1:0]       d_dst,
  input  logic [T_W-1:0]          d_tnew,
  input  logic                    ext_stall,
  output logic                    stall,
  output logic [NSTAGE*SEL_W-1:0] fwd_rs,
  output logic [NSTAGE*SEL_W-1:0] fwd_rt
);

  logic              stg_wen  [1:NSTAGE];
  logic [REG_AW-1:0] stg_dst  [1:NSTAGE];
  logic [T_W-1:0]    stg_tnew [1:NSTAGE];
  logic [REG_AW-1:0] stg_rs   [1:NSTAGE];
  logic [REG_AW-1:0] stg_rt   [1:NSTAGE];

  logic [REG_AW-1:0] cons_rs [0:NSTAGE-1];
  logic [REG_AW-1:0] cons_rt [0:NSTAGE-1];

  logic                    d_wr;
  logic                    hz;
  logic                    stall_int;
  logic                    rs_hit, rt_hit;
  logic [T_W-1:0]          rs_tn, rt_tn;
  logic [NSTAGE*SEL_W-1:0] fwd_rs_v, fwd_rt_v;

  assign d_wr      = d_valid & d_wen & (d_dst != '0);
  assign stall_int = hz | ext_stall;

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    if (k == 1) begin : g_first
      hazard_stage_reg #(.REG_AW(REG_AW), .T_W(T_W), .DEC(1'b0)) u_stage (
        .clk(clk), .reset(reset), .bubble(stall_int),
        .in_wen(d_wr), .in_dst(d_dst), .in_tnew(d_tnew), .in_rs(d_rs), .in_rt(d_rt),
        .wen(stg_wen[k]), .dst(stg_dst[k]), .tnew(stg_tnew[k]), .rs(stg_rs[k]), .rt(stg_rt[k])
      );
    end else begin : g_next
      hazard_stage_reg #(.REG_AW(REG_AW), .T_W(T_W), .DEC(1'b1)) u_stage (
        .clk(clk), .reset(reset), .bubble(1'b0),
        .in_wen(stg_wen[k-1]), .in_dst(stg_dst[k-1]), .in_tnew(stg_tnew[k-1]),
        .in_rs(stg_rs[k-1]), .in_rt(stg_rt[k-1]),
        .wen(stg_wen[k]), .dst(stg_dst[k]), .tnew(stg_tnew[k]), .rs(stg_rs[k]), .rt(stg_rt[k])
      );
    end
  end

  for (genvar c = 0; c < NSTAGE; c++) begin : g_cons
    if (c == 0) begin : g_d
      assign cons_rs[c] = d_rs;
      assign cons_rt[c] = d_rt;
    end else begin : g_pipe
      assign cons_rs[c] = stg_rs[c];
      assign cons_rt[c] = stg_rt[c];
    end
  end

  // Scan oldest to youngest so the nearest producer is the last one written.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_tn  = '0;
    rt_tn  = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (stg_wen[k] && (d_rs != '0) && (stg_dst[k] == d_rs)) begin
        rs_hit = 1'b1;
        rs_tn  = stg_tnew[k];
      end
      if (stg_wen[k] && (d_rt != '0) && (stg_dst[k] == d_rt)) begin
        rt_hit = 1'b1;
        rt_tn  = stg_tnew[k];
      end
    end
    hz = d_valid & ((d_use_rs & rs_hit & (rs_tn > d_tuse_rs)) |
                    (d_use_rt & rt_hit & (rt_tn > d_tuse_rt)));
  end

  // A nearer producer that is not ready yet still hides older ready writers.
  always_comb begin
    fwd_rs_v = '0;
    fwd_rt_v = '0;
    for (int c = 0; c < NSTAGE; c++) begin
      for (int k = NSTAGE; k > c; k--) begin
        if (stg_wen[k] && (cons_rs[c] != '0) && (stg_dst[k] == cons_rs[c])) begin
          fwd_rs_v[c*SEL_W +: SEL_W] = (stg_tnew[k] == '0) ? SEL_W'(k) : SEL_W'(FWD_RF);
        end
        if (stg_wen[k] && (cons_rt[c] != '0) && (stg_dst[k] == cons_rt[c])) begin
          fwd_rt_v[c*SEL_W +: SEL_W] = (stg_tnew[k] == '0) ? SEL_W'(k) : SEL_W'(FWD_RF);
        end
      end
    end
  end

  assign stall  = reset ? 1'b0 : stall_int;
  assign fwd_rs = reset ? '0 : fwd_rs_v;
  assign fwd_rt = reset ? '0 : fwd_rt_v;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline, using the Tuse/Tnew scheme.
- Tracks destination register, write-enable and remaining-latency (Tnew) for every stage after D (E, M, W for NSTAGE=3).
- Per cycle it produces the D-stage stall and the forwarding-mux selects for the rs/rt operand of every consumer stage.
- Generalises the fixed per-instruction T encoding of the decoder to arbitrary pipeline depth and latency width, and adds an external stall input.

Parameters:
- NSTAGE, 3: number of tracked stages after D (stage 1=E, 2=M, 3=W).
- REG_AW, 5: register address width.
- T_W, 3: Tnew/Tuse width.
- SEL_W, 2: forward-select width; must satisfy 2^SEL_W >= NSTAGE+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_valid  in  1  D holds a real instruction.
- d_rs  in  REG_AW  D source register rs.
- d_rt  in  REG_AW  D source register rt.
- d_use_rs  in  1  D instruction reads rs.
- d_use_rt  in  1  D instruction reads rt.
- d_tuse_rs  in  T_W  cycles after D at which rs is needed (0=D, 1=E, 2=M).
- d_tuse_rt  in  T_W  same, for rt.
- d_wen  in  1  D instruction writes the register file.
- d_dst  in  REG_AW  D destination register.
- d_tnew  in  T_W  advances after entering E until the result is forwardable (0 = already known in D, e.g. lui/jal; 1 = ALU; 2 = load).
- ext_stall  in  1  external stall request (e.g. mult/div busy), OR-ed into stall.
- stall  out  1  freeze PC and the D register; bubble into E.
- fwd_rs  out  NSTAGE*SEL_W  rs forward select; field c is for consumer stage c (0=D … NSTAGE-1).
- fwd_rt  out  NSTAGE*SEL_W  rt forward select; same layout.

Behaviour:
- State per tracked stage k=1..NSTAGE: wen_k, dst_k, tnew_k, rs_k, rt_k. Operand addresses travel with the instruction.
- Reset, taking effect at the clk edge: all stage state cleared to 0. While reset is high, stall=0 and all fwd fields=0 (forced combinationally). Reset mid-stall behaves the same; a pending stall is discarded.
- Advance, every non-reset edge:
  - stage k+1 <= stage k, with tnew decremented and saturating at 0;
  - stage NSTAGE's content is dropped.
  - Stage 1: if stall=0 it loads {d_valid&d_wen&(d_dst!=0), d_dst, d_tnew, d_rs, d_rt}. If stall=1 it loads a bubble (all zero); stages 2..NSTAGE still advance.
- Producer match for stage c, operand register r:
  - nearest k>c with wen_k=1 and dst_k==r and r!=0.
  - Only the nearest match counts; it hides older writers of the same register.
  - Register 0 never matches.
- Hazard stall, combinational: hz=1 if d_valid and, for an operand used with register r and tuse t, its nearest producer k in 1..NSTAGE has tnew_k > t.
- stall = hz | ext_stall.
- Forward select, field c:
  - = k if the nearest producer k>c exists and tnew_k==0;
  - else 0, meaning use the register-file or pipeline-register value.
  - Field 0 uses d_rs/d_rt; field c>=1 uses rs_c/rt_c.
  - Computed regardless of stall.
- Latency: stall and fwd are combinational from current state and D inputs, with zero cycles of latency. State updates one edge later.
- Simultaneous events:
  - ext_stall together with hz: single stall, single bubble.
  - A W-stage write and a D read of the same register with no nearer producer: fwd field 0 = NSTAGE (W forward). The register file is not relied on for same-cycle bypass.
- Saturation: tnew never wraps below 0. A d_tnew larger than NSTAGE simply remains nonzero in W and never forwards.

Decomposition:
- Shared package holds:
  - T_W and the Tuse/Tnew constants TUSE_D=0, TUSE_E=1, TUSE_M=2, TNEW_D=0, TNEW_E=1, TNEW_M=2;
  - forward-select encoding constants FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.
- One sub-module, hazard_stage_reg: a single tracked stage's register with bubble and saturating-decrement logic, instantiated NSTAGE times via generate.

Test Plan:
- addu $8 written, tnew=1, then beq reading $8 (tuse_rs=0) next cycle -> stall=1 for exactly 1 cycle, E bubble; the following cycle fwd_rs[0]=2 (M) and stall=0.
- lw $9 (tnew=2) then addu reading $9 (tuse=1) -> stall=1 for 1 cycle; after addu enters E, fwd_rs[1]=3 (W).
- lui $10 (tnew=0) then beq on $10 immediately -> stall=0, fwd_rs[0]=1 (E).
- addu $0, then beq reading $0 -> no stall, all fwd fields 0.
- Two writers of $11, in E (tnew=0) and in M (tnew=0); D reads $11 -> fwd field 0 = 1 (nearest producer wins).
- ext_stall=1 for 3 cycles with no hazard -> stall=1 for those cycles, 3 bubbles into E. Assert reset during the stall -> the next cycle has stall=0, all fwd=0, all stages empty.
